// File: rtl/regfile_fwd_pkg.sv
// Shared register-file constants and helpers for the decode-stage register file.
package regfile_fwd_pkg;

    localparam int unsigned REG_NUM      = 32;
    localparam int unsigned REG_NUM_LOG2 = 5;
    localparam int unsigned REG_DW       = 32;
    localparam int unsigned REG_AW       = REG_NUM_LOG2;

    localparam logic [REG_DW-1:0] ZERO_WORD    = '0;
    localparam logic [REG_AW-1:0] NOP_REG_ADDR = '0;
    localparam logic              RST_ENABLE   = 1'b1;
    localparam logic              WRITE_ENABLE = 1'b1;
    localparam logic              READ_ENABLE  = 1'b1;

endpackage : regfile_fwd_pkg

// File: rtl/regfile_fwd_fwd_mux.sv
// Per-port operand resolver: picks the youngest in-flight producer of addr,
// falling back to the array, and flags a hit on a not-yet-valid load result.
module fwd_mux #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic          ex_wreg,
    input  logic [AW-1:0] ex_wd,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_is_load,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_wd,
    input  logic [DW-1:0] mem_wdata,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_waddr,
    input  logic [DW-1:0] wb_wdata,
    input  logic [DW-1:0] arr_data,
    output logic [DW-1:0] data_c,
    output logic          load_hit_c
);

    logic addr_live;
    assign addr_live = re && (addr != AW'(0));

    // Youngest producer wins: ex, then mem, then write-back, then the array.
    always_comb begin
        data_c = '0;
        if (addr_live) begin
            if (ex_wreg && (ex_wd == addr)) begin
                data_c = ex_wdata;
            end else if (mem_wreg && (mem_wd == addr)) begin
                data_c = mem_wdata;
            end else if (wb_we && (wb_waddr == addr)) begin
                data_c = wb_wdata;
            end else begin
                data_c = arr_data;
            end
        end
    end

    assign load_hit_c = addr_live && ex_wreg && ex_is_load && (ex_wd == addr);

endmodule : fwd_mux

// File: rtl/regfile_fwd.sv
// 32x32 architectural register file with ex/mem/wb bypass on both read ports
// and a load-use stall request.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int unsigned NREG = REG_NUM,
    parameter int unsigned DW   = REG_DW,
    parameter int unsigned AW   = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re1,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic          re2,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2,
    input  logic          ex_wreg,
    input  logic [AW-1:0] ex_wd,
    input  logic [DW-1:0] ex_wdata,
    input  logic          ex_is_load,
    input  logic          mem_wreg,
    input  logic [AW-1:0] mem_wd,
    input  logic [DW-1:0] mem_wdata,
    output logic          stallreq
);

    // r0 is never stored; it is synthesised as a constant zero on read.
    logic [DW-1:0] regs_q [NREG-1:1];
    logic [DW-1:0] regs_d [NREG-1:1];

    logic [DW-1:0] arr_data1, arr_data2;
    logic [DW-1:0] mux_data1, mux_data2;
    logic          load_hit1, load_hit2;

    always_comb begin
        for (int i = 1; i < int'(NREG); i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rst) begin
            for (int i = 1; i < int'(NREG); i++) begin
                regs_d[i] = '0;
            end
        end else if (we && (waddr != AW'(0)) && (int'(waddr) < int'(NREG))) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 1; i < int'(NREG); i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Out-of-range or zero addresses read as zero rather than X.
    always_comb begin
        arr_data1 = '0;
        arr_data2 = '0;
        if ((raddr1 != AW'(0)) && (int'(raddr1) < int'(NREG))) arr_data1 = regs_q[raddr1];
        if ((raddr2 != AW'(0)) && (int'(raddr2) < int'(NREG))) arr_data2 = regs_q[raddr2];
    end

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd1 (
        .re         (re1),
        .addr       (raddr1),
        .ex_wreg    (ex_wreg),
        .ex_wd      (ex_wd),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .wb_we      (we),
        .wb_waddr   (waddr),
        .wb_wdata   (wdata),
        .arr_data   (arr_data1),
        .data_c     (mux_data1),
        .load_hit_c (load_hit1)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd2 (
        .re         (re2),
        .addr       (raddr2),
        .ex_wreg    (ex_wreg),
        .ex_wd      (ex_wd),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .wb_we      (we),
        .wb_waddr   (waddr),
        .wb_wdata   (wdata),
        .arr_data   (arr_data2),
        .data_c     (mux_data2),
        .load_hit_c (load_hit2)
    );

    assign rdata1   = rst ? '0 : mux_data1;
    assign rdata2   = rst ? '0 : mux_data2;
    assign stallreq = !rst && (load_hit1 || load_hit2);

endmodule : regfile_fwd

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: reset, r0, write-through, bypass priority,
// load-use stall and disabled reads.
module tb_regfile_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_wreg, ex_is_load, mem_wreg;
    logic [4:0]  ex_wd, mem_wd;
    logic [31:0] ex_wdata, mem_wdata;
    logic        stallreq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_fwd dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .ex_wreg    (ex_wreg),
        .ex_wd      (ex_wd),
        .ex_wdata   (ex_wdata),
        .ex_is_load (ex_is_load),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .stallreq   (stallreq)
    );

    task automatic idle();
        we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
    endtask

    // Write-back one register across a rising edge, then return at the falling edge.
    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        we = 1; waddr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        we = 0; waddr = 0; wdata = 0;
    endtask

    task automatic test_reset();
        wb_write(5'd5, 32'hDEADBEEF);
        re1 = 1; raddr1 = 5;
        #1;
        n_checks++;
        if (rdata1 !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL pre_reset_r5 got %h want %h", rdata1, 32'hDEADBEEF);
        end
        rst = 1;
        re2 = 1; raddr2 = 5;
        ex_wreg = 1; ex_is_load = 1; ex_wd = 5; ex_wdata = 32'h1111;
        we = 1; waddr = 6; wdata = 32'h66;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata1 got %h want 0", rdata1); end
        n_checks++;
        if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_rdata2 got %h want 0", rdata2); end
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL rst_stallreq got %b want 0", stallreq); end
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        idle();
        re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 6;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL post_rst_r5 got %h want 0", rdata1); end
        n_checks++;
        if (rdata2 !== 32'h0) begin n_fail++; $display("FAIL rst_cycle_write_r6 got %h want 0", rdata2); end
        wb_write(5'd6, 32'h600D);
        re2 = 1; raddr2 = 6;
        #1;
        n_checks++;
        if (rdata2 !== 32'h600D) begin n_fail++; $display("FAIL first_write_after_rst got %h want 600d", rdata2); end
        idle();
    endtask

    task automatic test_r0();
        wb_write(5'd0, 32'hFFFFFFFF);
        re1 = 1; raddr1 = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_after_write got %h want 0", rdata1); end
        ex_wreg = 1; ex_wd = 0; ex_wdata = 32'h1234;
        mem_wreg = 1; mem_wd = 0; mem_wdata = 32'h5678;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL r0_ex_bypass got %h want 0", rdata1); end
        idle();
    endtask

    task automatic test_write_through();
        we = 1; waddr = 7; wdata = 32'h00000A5A;
        re1 = 1; raddr1 = 7;
        #1;
        n_checks++;
        if (rdata1 !== 32'h00000A5A) begin n_fail++; $display("FAIL wt_same_cycle got %h want a5a", rdata1); end
        @(posedge clk);
        @(negedge clk);
        we = 0; waddr = 0; wdata = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'h00000A5A) begin n_fail++; $display("FAIL wt_next_cycle got %h want a5a", rdata1); end
        idle();
    endtask

    task automatic test_forward_priority();
        wb_write(5'd3, 32'd1);
        we = 1; waddr = 3; wdata = 32'd2;
        mem_wreg = 1; mem_wd = 3; mem_wdata = 32'd3;
        ex_wreg = 1; ex_wd = 3; ex_wdata = 32'd4;
        re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 3;
        #1;
        n_checks++;
        if (rdata1 !== 32'd4) begin n_fail++; $display("FAIL prio_ex got %0d want 4", rdata1); end
        n_checks++;
        if (rdata2 !== 32'd4) begin n_fail++; $display("FAIL prio_ex_port2 got %0d want 4", rdata2); end
        ex_wreg = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'd3) begin n_fail++; $display("FAIL prio_mem got %0d want 3", rdata1); end
        mem_wreg = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'd2) begin n_fail++; $display("FAIL prio_wb got %0d want 2", rdata1); end
        we = 0;
        #1;
        n_checks++;
        if (rdata1 !== 32'd1) begin n_fail++; $display("FAIL prio_array got %0d want 1", rdata1); end
        // A producer for a different register must not be selected.
        mem_wreg = 1; mem_wd = 4; mem_wdata = 32'd99;
        #1;
        n_checks++;
        if (rdata1 !== 32'd1) begin n_fail++; $display("FAIL prio_other_addr got %0d want 1", rdata1); end
        idle();
    endtask

    task automatic test_load_use();
        ex_wreg = 1; ex_is_load = 1; ex_wd = 9; re2 = 1; raddr2 = 9;
        #1;
        n_checks++;
        if (stallreq !== 1'b1) begin n_fail++; $display("FAIL lu_port2 got %b want 1", stallreq); end
        re2 = 0;
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lu_re2_off got %b want 0", stallreq); end
        re2 = 1; ex_wd = 0; raddr2 = 0;
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lu_r0 got %b want 0", stallreq); end
        ex_wd = 9; raddr2 = 9; ex_is_load = 0;
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lu_not_load got %b want 0", stallreq); end
        ex_is_load = 1; re2 = 0; re1 = 1; raddr1 = 9;
        #1;
        n_checks++;
        if (stallreq !== 1'b1) begin n_fail++; $display("FAIL lu_port1 got %b want 1", stallreq); end
        ex_wreg = 0;
        #1;
        n_checks++;
        if (stallreq !== 1'b0) begin n_fail++; $display("FAIL lu_no_wreg got %b want 0", stallreq); end
        idle();
    endtask

    task automatic test_disabled_read();
        wb_write(5'd7, 32'h55);
        re1 = 0; raddr1 = 7; re2 = 1; raddr2 = 7;
        #1;
        n_checks++;
        if (rdata1 !== 32'h0) begin n_fail++; $display("FAIL dis_rdata1 got %h want 0", rdata1); end
        n_checks++;
        if (rdata2 !== 32'h55) begin n_fail++; $display("FAIL en_rdata2 got %h want 55", rdata2); end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        test_reset();
        test_r0();
        test_write_through();
        test_forward_priority();
        test_load_use();
        test_disabled_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_fwd

// File: doc/regfile_fwd.md
# regfile_fwd

General-purpose register file for the five-stage pipeline, with an integrated operand-forwarding network. It owns the 32×32-bit architectural registers and serves the decode stage's two operand reads. It accepts write-back results and resolves RAW hazards by bypassing in-flight results from the execute and memory stages. It also raises a stall request on load-use hazards.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; register 0 is hardwired to zero.
- `DW`, 32: data width (`RegBus`).
- `AW`, 5: register address width (`RegAddrBus`).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `we` in 1: write-back enable.
- `waddr` in AW: write-back destination.
- `wdata` in DW: write-back data.
- `re1` in 1: read port 1 enable.
- `raddr1` in AW: read port 1 address.
- `rdata1` out DW: read port 1 data, combinational.
- `re2` in 1: read port 2 enable.
- `raddr2` in AW: read port 2 address.
- `rdata2` out DW: read port 2 data, combinational.
- `ex_wreg` in 1: execute stage will write a register.
- `ex_wd` in AW: execute stage destination.
- `ex_wdata` in DW: execute stage result.
- `ex_is_load` in 1: execute-stage instruction is a load; `ex_wdata` is not yet valid.
- `mem_wreg` in 1: memory stage will write a register.
- `mem_wd` in AW: memory stage destination.
- `mem_wdata` in DW: memory stage result.
- `stallreq` out 1: decode must stall one cycle (load-use hazard).

## Operation
- Storage: registers 1..31 are flops. Register 0 is never stored and always reads 0.
- Write: on a rising edge with `rst`=0, `we`=1 and `waddr`≠0, `regs[waddr]` ← `wdata`. A write to address 0 is discarded.
- Read, per port, evaluated in priority order:
  1. `rst`=1 → 0.
  2. `re`=0 → 0.
  3. addr=0 → 0.
  4. `ex_wreg` and `ex_wd`=addr → `ex_wdata`.
  5. `mem_wreg` and `mem_wd`=addr → `mem_wdata`.
  6. `we` and `waddr`=addr → `wdata` (same-cycle write-through).
  7. Otherwise → `regs[addr]`.
- Youngest producer wins: ex over mem over wb over the array.
- Load-use:
  - `stallreq`=1 iff `rst`=0, `ex_wreg`=1, `ex_is_load`=1 and `ex_wd`≠0, and some port with `re`=1 has addr=`ex_wd`.
  - The data on that port is don't-care while stalled, but it still follows the priority rule.
- Both ports may read the same address. Each resolves independently and identically.
- Simultaneous ex, mem and wb writes to the same address are legal. Only the priority rule applies.

## Timing
- Reads and `stallreq` are purely combinational; zero-cycle latency from inputs.
- A write is visible in the array one edge after `we` is sampled, and is visible through bypass in the same cycle.
- Reset:
  - While `rst`=1 at an edge, all of regs[1..31] ← 0 and any write is ignored.
  - While `rst`=1, `rdata1`=`rdata2`=0 and `stallreq`=0.
- Reset mid-operation discards in-flight writes presented in the reset cycle. After `rst` falls, the first write at the next edge is accepted normally.
- No X propagation: unread ports drive 0.

## Structure
- Shared defines (existing global include): `RegBus`, `RegAddrBus`, `RegNum`=32, `RegNumLog2`=5, `ZeroWord`, `RstEnable`, `WriteEnable`, `ReadEnable`, `NOPRegAddr`.
- Sub-module `fwd_mux`: one per read port.
  - Inputs: re, addr, the three producer triples, array data.
  - Outputs: resolved data and a `load_hit` flag.
- Top level: array, write logic, two `fwd_mux` instances, and `stallreq` as the OR of the two `load_hit` flags gated by `rst`.

## Test plan
- Reset: write 0xDEADBEEF to r5 and reset for 1 cycle. Read r5 afterwards → 0. During reset, `rdata1`/`rdata2`=0 and `stallreq`=0.
- R0 protection: `we`=1, `waddr`=0, `wdata`=0xFFFFFFFF. Next cycle read r0 → 0, including when `ex_wd`=0 with `ex_wdata`=0x1234.
- Write-through:
  - Same cycle `we`=1, r7, 0x00000A5A, with `raddr1`=7 → `rdata1`=0x00000A5A.
  - Next cycle, no write, read r7 → 0x00000A5A.
- Forward priority: array r3=1, wb r3=2, mem r3=3, ex r3=4 → `rdata1`=4. Drop ex → 3. Drop mem → 2. Drop wb → 1.
- Load-use:
  - `ex_wreg`=1, `ex_is_load`=1, `ex_wd`=9, `re2`=1, `raddr2`=9 → `stallreq`=1.
  - Same with `re2`=0, or with `ex_wd`=0 → `stallreq`=0.
- Disabled read: `re1`=0, `raddr1`=7 with r7=0x55 → `rdata1`=0.
